// File: rtl/mp_icache_maint_pkg.sv
// ----------------------------------------------------------------------------
// mp_icache_maint_pkg
// Shared types for the icache maintenance arbiter: the requester operation
// encoding and the arbiter FSM states.
// ----------------------------------------------------------------------------
package mp_icache_maint_pkg;

    localparam int unsigned ADDR_W = 32;

    // Requester operation encoding (matches the 2-bit req_op_i field).
    typedef enum logic [1:0] {
        OP_ENABLE    = 2'b00,
        OP_DISABLE   = 2'b01,
        OP_FLUSH     = 2'b10,
        OP_SEL_FLUSH = 2'b11
    } maint_op_e;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_EN,
        WAIT_DIS,
        WAIT_FL,
        WAIT_SEL,
        RESP
    } maint_state_e;

endpackage

// File: rtl/mp_icache_rr_arbiter.sv
// ----------------------------------------------------------------------------
// mp_icache_rr_arbiter
// NB_REQ-way round-robin arbiter. The grant is the first active request at or
// after the pointer (wrapping). When enable is high and a grant is made, the
// pointer moves to the slot after the winner.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   req            request vector
//   enable         grant is being consumed this cycle (pointer update)
//   grant          one-hot grant (all zero when no request)
//   grant_idx      binary index of the grant
//   any            at least one request is active
// ----------------------------------------------------------------------------
module mp_icache_rr_arbiter #(
    parameter int unsigned NB_REQ = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NB_REQ-1:0]         req,
    input  logic                      enable,
    output logic [NB_REQ-1:0]         grant,
    output logic [$clog2(NB_REQ)-1:0] grant_idx,
    output logic                      any
);

    localparam int unsigned IDX_W = $clog2(NB_REQ);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] cand;

    // Modulo-NB_REQ addition; NB_REQ need not be a power of two.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input int unsigned      off);
        int unsigned sum;
        sum = 32'(base) + off;
        return IDX_W'(sum % NB_REQ);
    endfunction

    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = '0;
        for (int unsigned k = 0; k < NB_REQ; k++) begin
            cand = wrap_add(ptr, k);
            if (!any && req[cand]) begin
                any       = 1'b1;
                grant_idx = cand;
            end
        end
        grant[grant_idx] = any;
    end

    // NOTE: registers are written with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr <= '0;
        end else if (enable && any) begin
            ptr <= wrap_add(grant_idx, 1);
        end
    end

endmodule

// File: rtl/mp_icache_maint_arbiter.sv
// ----------------------------------------------------------------------------
// mp_icache_maint_arbiter
// Shares the cluster icache maintenance interface (bypass, flush, selective
// flush) among NB_REQ requesters. One operation is admitted at a time in
// round-robin order; the cache handshake is driven until acknowledged or
// until TIMEOUT expires, then a one-cycle completion pulse is returned to the
// requester that issued the operation.
// Ports:
//   clk_i, rst_ni                    clock, asynchronous active-low reset
//   req_valid_i/op_i/addr_i          per-requester operation request
//   req_ready_o                      one-hot accept (combinational, IDLE only)
//   done_o, done_err_o               one-hot completion pulse, 1 = timed out
//   bypass_req_o, bypass_ack_i       bypass level and per-bank bypass state
//   flush_req_o, flush_ack_i         full flush handshake
//   sel_flush_req_o/addr_o/ack_i     selective flush handshake
//   busy_o                           operation in progress
// ----------------------------------------------------------------------------
module mp_icache_maint_arbiter
    import mp_icache_maint_pkg::*;
#(
    parameter int unsigned NB_REQ   = 4,
    parameter int unsigned NB_BANKS = 4,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NB_REQ-1:0]              req_valid_i,
    input  logic [NB_REQ-1:0][1:0]         req_op_i,
    input  logic [NB_REQ-1:0][ADDR_W-1:0]  req_addr_i,
    output logic [NB_REQ-1:0]              req_ready_o,
    output logic [NB_REQ-1:0]              done_o,
    output logic                           done_err_o,
    output logic                           bypass_req_o,
    input  logic [NB_BANKS-1:0]            bypass_ack_i,
    output logic                           flush_req_o,
    input  logic                           flush_ack_i,
    output logic                           sel_flush_req_o,
    output logic [ADDR_W-1:0]              sel_flush_addr_o,
    input  logic                           sel_flush_ack_i,
    output logic                           busy_o
);

    localparam int unsigned IDX_W = $clog2(NB_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    // Abort once TIMEOUT-1 wait cycles have passed without ack, so the error
    // pulse lands exactly TIMEOUT cycles after the accept.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

    maint_state_e      state;
    logic [IDX_W-1:0]  id;
    logic [CNT_W-1:0]  cnt;

    logic [NB_REQ-1:0] grant;
    logic [IDX_W-1:0]  grant_idx;
    logic              any_valid;
    logic              idle;
    logic              ack_ok;
    maint_op_e         grant_op;

    assign idle     = (state == IDLE);
    assign grant_op = maint_op_e'(req_op_i[grant_idx]);

    mp_icache_rr_arbiter #(
        .NB_REQ(NB_REQ)
    ) u_rr (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req      (req_valid_i),
        .enable   (idle),
        .grant    (grant),
        .grant_idx(grant_idx),
        .any      (any_valid)
    );

    assign req_ready_o = idle ? grant : '0;
    assign busy_o      = !idle;

    // Completion condition of the wait state currently occupied; acks seen
    // in IDLE or RESP fall to the default and are ignored.
    always_comb begin
        ack_ok = 1'b0;
        unique case (state)
            WAIT_EN:  ack_ok = (bypass_ack_i == '0);
            WAIT_DIS: ack_ok = &bypass_ack_i;
            WAIT_FL:  ack_ok = flush_ack_i;
            WAIT_SEL: ack_ok = sel_flush_ack_i;
            default:  ack_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state            <= IDLE;
            id               <= '0;
            cnt              <= '0;
            done_o           <= '0;
            done_err_o       <= 1'b0;
            bypass_req_o     <= 1'b1;   // cache stays bypassed until enabled
            flush_req_o      <= 1'b0;
            sel_flush_req_o  <= 1'b0;
            sel_flush_addr_o <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_valid) begin
                        id  <= grant_idx;
                        cnt <= '0;
                        unique case (grant_op)
                            OP_ENABLE: begin
                                bypass_req_o <= 1'b0;
                                state        <= WAIT_EN;
                            end
                            OP_DISABLE: begin
                                bypass_req_o <= 1'b1;
                                state        <= WAIT_DIS;
                            end
                            OP_FLUSH: begin
                                flush_req_o <= 1'b1;
                                state       <= WAIT_FL;
                            end
                            default: begin
                                sel_flush_req_o  <= 1'b1;
                                sel_flush_addr_o <= req_addr_i[grant_idx];
                                state            <= WAIT_SEL;
                            end
                        endcase
                    end
                end
                WAIT_EN, WAIT_DIS, WAIT_FL, WAIT_SEL: begin
                    // A late ack on the timeout cycle still counts as success.
                    if (ack_ok || cnt == CNT_LAST) begin
                        state           <= RESP;
                        done_o          <= NB_REQ'(1) << id;
                        done_err_o      <= !ack_ok;
                        flush_req_o     <= 1'b0;
                        sel_flush_req_o <= 1'b0;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    done_o     <= '0;
                    done_err_o <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mp_icache_maint_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mp_icache_maint_arbiter
// Directed bench: a table of single-requester operations with hand-computed
// completion mask, status, latency and bypass level, followed by hand-written
// sequences for arbitration order, async reset and spurious acks.
// ----------------------------------------------------------------------------
module tb_mp_icache_maint_arbiter;
    import mp_icache_maint_pkg::*;

    localparam int unsigned NB_REQ   = 4;
    localparam int unsigned NB_BANKS = 4;
    localparam int unsigned TIMEOUT  = 64;

    logic                   clk_i = 1'b0;
    logic                   rst_ni = 1'b0;
    logic [3:0]             req_valid_i = '0;
    logic [3:0][1:0]        req_op_i = '0;
    logic [3:0][31:0]       req_addr_i = '0;
    logic [3:0]             req_ready_o;
    logic [3:0]             done_o;
    logic                   done_err_o;
    logic                   bypass_req_o;
    logic [3:0]             bypass_ack_i = 4'hF;
    logic                   flush_req_o;
    logic                   flush_ack_i = 1'b0;
    logic                   sel_flush_req_o;
    logic [31:0]            sel_flush_addr_o;
    logic                   sel_flush_ack_i = 1'b0;
    logic                   busy_o;

    int n_vec = 0;
    int n_bad = 0;

    mp_icache_maint_arbiter #(
        .NB_REQ  (NB_REQ),
        .NB_BANKS(NB_BANKS),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .req_valid_i     (req_valid_i),
        .req_op_i        (req_op_i),
        .req_addr_i      (req_addr_i),
        .req_ready_o     (req_ready_o),
        .done_o          (done_o),
        .done_err_o      (done_err_o),
        .bypass_req_o    (bypass_req_o),
        .bypass_ack_i    (bypass_ack_i),
        .flush_req_o     (flush_req_o),
        .flush_ack_i     (flush_ack_i),
        .sel_flush_req_o (sel_flush_req_o),
        .sel_flush_addr_o(sel_flush_addr_o),
        .sel_flush_ack_i (sel_flush_ack_i),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // One operation: ack_cycle is the wait cycle (1 = first cycle after
    // accept) on which the cache acknowledges; 0 means never.
    typedef struct {
        int          req;
        maint_op_e   op;
        logic [31:0] addr;
        int          ack_cycle;
        logic [3:0]  exp_done;
        logic        exp_err;
        int          exp_lat;
        logic        exp_bypass;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cache model: bank state switches to the target on the ack cycle and
    // stays there; flush acks are single-cycle pulses.
    task automatic drive_acks(input vec_t v, input int cyc);
        flush_ack_i     = (v.op == OP_FLUSH)     && (cyc == v.ack_cycle);
        sel_flush_ack_i = (v.op == OP_SEL_FLUSH) && (cyc == v.ack_cycle);
        if (cyc == v.ack_cycle && v.op == OP_ENABLE)  bypass_ack_i = 4'h0;
        if (cyc == v.ack_cycle && v.op == OP_DISABLE) bypass_ack_i = 4'hF;
    endtask

    // Entered and left at posedge+1 of an IDLE cycle.
    task automatic run_vec(input vec_t v, input int idx);
        logic       got;
        logic [3:0] got_done;
        logic       got_err;
        int         lat;
        got = 1'b0; got_done = '0; got_err = 1'b0; lat = 0;
        req_op_i[v.req]   = v.op;
        req_addr_i[v.req] = v.addr;
        req_valid_i       = 4'b0001 << v.req;
        #1 check($sformatf("v%0d ready", idx), 64'(req_ready_o), 64'(4'b0001 << v.req));
        @(posedge clk_i); #1;
        req_valid_i = '0;
        for (int cyc = 1; cyc <= int'(TIMEOUT) + 4 && !got; cyc++) begin
            drive_acks(v, cyc);
            #1;
            if (done_o != '0) begin
                got = 1'b1; lat = cyc; got_done = done_o; got_err = done_err_o;
            end else begin
                if (cyc == 1 && v.op == OP_FLUSH)
                    check($sformatf("v%0d flush_req", idx), 64'(flush_req_o), 64'd1);
                if (cyc == 1 && v.op == OP_SEL_FLUSH)
                    check($sformatf("v%0d sel_req_addr", idx), {31'd0, sel_flush_req_o, sel_flush_addr_o}, {31'd0, 1'b1, v.addr});
                @(posedge clk_i); #1;
            end
        end
        flush_ack_i = 1'b0; sel_flush_ack_i = 1'b0;
        if (!got) begin
            check($sformatf("v%0d done_seen", idx), 64'd0, 64'd1);
        end else begin
            check($sformatf("v%0d done", idx), 64'(got_done), 64'(v.exp_done));
            check($sformatf("v%0d err", idx), 64'(got_err), 64'(v.exp_err));
            check($sformatf("v%0d latency", idx), 64'(lat), 64'(v.exp_lat));
            check($sformatf("v%0d bypass_req", idx), 64'(bypass_req_o), 64'(v.exp_bypass));
            check($sformatf("v%0d reqs_low_at_done", idx), {flush_req_o, sel_flush_req_o}, 64'd0);
        end
        @(posedge clk_i); #1;
        check($sformatf("v%0d after_done", idx), {done_o, done_err_o, busy_o, flush_req_o, sel_flush_req_o}, 64'd0);
    endtask

    // FLUSH from the requesters in mask with an immediate ack; expects the
    // given grant, then the done pulse for that requester only.
    task automatic serve(input string name, input logic [3:0] mask, input logic [3:0] exp_grant, input logic drop);
        req_valid_i = mask;
        #1 check({name, " ready"}, 64'(req_ready_o), 64'(exp_grant));
        @(posedge clk_i); #1;
        if (drop) req_valid_i = mask & ~exp_grant;
        check({name, " no_grant_busy"}, 64'(req_ready_o), 64'd0);
        flush_ack_i = 1'b1;
        @(posedge clk_i); #1;
        flush_ack_i = 1'b0;
        check({name, " done"}, 64'(done_o), 64'(exp_grant));
        @(posedge clk_i); #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("reset outputs", {req_ready_o, done_o, done_err_o, bypass_req_o, flush_req_o, sel_flush_req_o, busy_o}, {4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        check("reset sel_addr", 64'(sel_flush_addr_o), 64'd0);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
    endtask

    initial begin
        logic [3:0] acc;
        vec_t en_vec;

        //          req op            addr          ack done     err  lat bypass
        vecs[0]  = '{0, OP_ENABLE,    32'h0,         6, 4'b0001, 1'b0,  7, 1'b0};
        vecs[1]  = '{1, OP_ENABLE,    32'h0,         0, 4'b0010, 1'b0,  2, 1'b0};
        vecs[2]  = '{2, OP_SEL_FLUSH, 32'h1C00_8040, 4, 4'b0100, 1'b0,  5, 1'b0};
        vecs[3]  = '{3, OP_DISABLE,   32'h0,         3, 4'b1000, 1'b0,  4, 1'b1};
        vecs[4]  = '{0, OP_FLUSH,     32'h0,         1, 4'b0001, 1'b0,  2, 1'b1};
        vecs[5]  = '{1, OP_FLUSH,     32'h0,         0, 4'b0010, 1'b1, 64, 1'b1};
        vecs[6]  = '{2, OP_ENABLE,    32'h0,         0, 4'b0100, 1'b1, 64, 1'b0};
        vecs[7]  = '{3, OP_DISABLE,   32'h0,         0, 4'b1000, 1'b0,  2, 1'b1};
        vecs[8]  = '{0, OP_SEL_FLUSH, 32'hDEAD_BEEF, 0, 4'b0001, 1'b1, 64, 1'b1};
        vecs[9]  = '{0, OP_FLUSH,     32'h0,        64, 4'b0001, 1'b1, 64, 1'b1};
        vecs[10] = '{1, OP_FLUSH,     32'h0,        63, 4'b0010, 1'b0, 64, 1'b1};

        do_reset();

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Pointer is now 2: req3 wins over req1, then req1, and the pointer
        // is back at 2 so req2 wins over req1.
        req_op_i = {4{OP_FLUSH}};
        serve("rr 1+3", 4'b1010, 4'b1000, 1'b1);
        serve("rr 1",   4'b0010, 4'b0010, 1'b1);
        serve("rr ptr2", 4'b0110, 4'b0100, 1'b1);

        // Fresh pointer, all requesters continuously valid.
        req_valid_i = '0;
        do_reset();
        for (int i = 0; i < 8; i++)
            serve($sformatf("rr all op%0d", i), 4'b1111, 4'b0001 << (i % 4), 1'b0);
        req_valid_i = '0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;

        // Async reset while waiting on a flush.
        en_vec = '{0, OP_ENABLE, 32'h0, 1, 4'b0001, 1'b0, 2, 1'b0};
        bypass_ack_i = 4'hF;
        run_vec(en_vec, 90);
        req_op_i[1] = OP_FLUSH;
        req_valid_i = 4'b0010;
        @(posedge clk_i); #1;
        req_valid_i = '0;
        check("rst flush_req before", 64'(flush_req_o), 64'd1);
        @(posedge clk_i); #2;
        rst_ni = 1'b0;
        #1 check("rst mid-op outputs", {flush_req_o, bypass_req_o, busy_o}, {1'b0, 1'b1, 1'b0});
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        acc = '0;
        for (int i = 0; i < 5; i++) begin
            flush_ack_i = (i == 1);
            @(posedge clk_i); #1;
            acc |= done_o;
        end
        flush_ack_i = 1'b0;
        check("rst no done after release", 64'(acc), 64'd0);

        // Spurious acks while idle are ignored.
        acc = '0;
        for (int i = 0; i < 3; i++) begin
            flush_ack_i = 1'b1; sel_flush_ack_i = 1'b1; bypass_ack_i = ~bypass_ack_i;
            @(posedge clk_i); #1;
            acc |= done_o;
            acc[0] = acc[0] | busy_o;
        end
        flush_ack_i = 1'b0; sel_flush_ack_i = 1'b0;
        check("spurious ack idle", 64'(acc), 64'd0);
        check("spurious bypass_req", 64'(bypass_req_o), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no end, expected $finish");
        $fatal(1, "watchdog");
    end

endmodule
